bf16_div_seq: RTL and testbench

- Iterative bfloat16 divider, the inverse operation of the team's combinational bf16 multiplier.
- Computes quot = dividend / divisor using restoring mantissa division, one quotient bit per cycle.
- Uses the same 2-bit error encoding as the multiplier: 11 NaN, 01 overflow/div-by-zero, 10 underflow, 00 ok.
- Sits beside the multiplier in the FP datapath behind a valid/ready handshake on both input and output.

---
 rtl/bf16_pkg.sv | 31 +++
 rtl/bf16_classify.sv | 29 ++
 rtl/bf16_div_seq.sv | 201 ++++++++++++++++++++
 tb/tb_bf16_div_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// ============================================================================
// bf16_pkg : shared widths, error codes and FSM state type for the bf16 units
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package bf16_pkg;

  localparam int BF16_W      = 16;
  localparam int BF16_EXP_W  = 8;
  localparam int BF16_FRAC_W = 7;
  localparam int BF16_ERR_W  = 2;
  localparam int EXP_BIAS    = 127;

  localparam logic [BF16_ERR_W-1:0] ERR_NONE = 2'b00;
  localparam logic [BF16_ERR_W-1:0] ERR_OVF  = 2'b01;
  localparam logic [BF16_ERR_W-1:0] ERR_UNF  = 2'b10;
  localparam logic [BF16_ERR_W-1:0] ERR_NAN  = 2'b11;

  localparam logic [BF16_EXP_W-1:0]  EXP_ONES = 8'hFF;
  localparam logic [BF16_FRAC_W-1:0] NAN_FRAC = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bf16_classify.sv
// ============================================================================
// bf16_classify : combinational NaN/Inf/zero decoder (exp=0 counts as zero)
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module bf16_classify #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
) (
  input  logic [EXP_WIDTH-1:0]  i_exp,
  input  logic [FRAC_WIDTH-1:0] i_frac,
  output logic                  o_is_nan,
  output logic                  o_is_inf,
  output logic                  o_is_zero
);

  logic w_exp_ones;
  logic w_frac_zero;

  assign w_exp_ones  = &i_exp;
  assign w_frac_zero = ~|i_frac;
  assign o_is_nan    = w_exp_ones & ~w_frac_zero;
  assign o_is_inf    = w_exp_ones & w_frac_zero;
  assign o_is_zero   = ~|i_exp;

endmodule

`default_nettype wire

// File: rtl/bf16_div_seq.sv
// ============================================================================
// bf16_div_seq : iterative restoring bf16 divider, one quotient bit per cycle.
// Optional macro FP_DIV_ROUND_EN adds a guard iteration and round-to-nearest-even.
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module bf16_div_seq
  import bf16_pkg::*;
#(
  parameter int DATA_WIDTH  = BF16_W,
  parameter int EXP_WIDTH   = BF16_EXP_W,
  parameter int FRAC_WIDTH  = BF16_FRAC_W,
  parameter int ERROR_WIDTH = BF16_ERR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  dividend,
  input  logic [DATA_WIDTH-1:0]  divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  quot,
  output logic [ERROR_WIDTH-1:0] error
);

  localparam int MANT_W = FRAC_WIDTH + 1;
  localparam int REM_W  = FRAC_WIDTH + 2;
`ifdef FP_DIV_ROUND_EN
  localparam int NITER  = FRAC_WIDTH + 3;
`else
  localparam int NITER  = FRAC_WIDTH + 2;
`endif
  localparam int XW     = EXP_WIDTH + 2;

  localparam logic [3:0]             c_cnt_init = 4'(NITER - 1);
  localparam logic signed [XW-1:0]   c_bias     = XW'(EXP_BIAS);
  localparam logic signed [XW-1:0]   c_exp_max  = XW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [XW-1:0]   c_exp_zero = '0;
  localparam logic signed [XW-1:0]   c_one      = XW'(1);

  state_t                   r_state, w_state_next;
  logic [REM_W-1:0]         r_rem;
  logic [MANT_W-1:0]        r_div;
  logic [NITER-2:0]         r_q;
  logic [3:0]               r_cnt;
  logic signed [XW-1:0]     r_exp;
  logic                     r_sign;
  logic [DATA_WIDTH-1:0]    r_quot;
  logic [ERROR_WIDTH-1:0]   r_err;

  logic                     w_sign;
  logic [EXP_WIDTH-1:0]     w_e1, w_e2;
  logic [FRAC_WIDTH-1:0]    w_f1, w_f2;
  logic                     w_nan1, w_inf1, w_zero1, w_nan2, w_inf2, w_zero2;
  logic                     w_special;
  logic [DATA_WIDTH-1:0]    w_spec_quot;
  logic [ERROR_WIDTH-1:0]   w_spec_err;

  logic                     w_ge, w_hi, w_last;
  logic [REM_W-1:0]         w_diff, w_rem_next;
  logic [NITER-1:0]         w_q_next;
  logic [FRAC_WIDTH-1:0]    w_frac, w_frac_fin;
  logic signed [XW-1:0]     w_exp, w_exp_fin;
  logic [DATA_WIDTH-1:0]    w_res_quot;
  logic [ERROR_WIDTH-1:0]   w_res_err;
`ifdef FP_DIV_ROUND_EN
  logic                     w_guard, w_sticky;
  logic [FRAC_WIDTH:0]      w_frac_sum;
`endif

  assign w_sign = dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
  assign w_e1   = dividend[DATA_WIDTH-2 -: EXP_WIDTH];
  assign w_e2   = divisor[DATA_WIDTH-2 -: EXP_WIDTH];
  assign w_f1   = dividend[FRAC_WIDTH-1:0];
  assign w_f2   = divisor[FRAC_WIDTH-1:0];

  bf16_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_cls_dividend (
    .i_exp(w_e1), .i_frac(w_f1), .o_is_nan(w_nan1), .o_is_inf(w_inf1), .o_is_zero(w_zero1)
  );

  bf16_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_cls_divisor (
    .i_exp(w_e2), .i_frac(w_f2), .o_is_nan(w_nan2), .o_is_inf(w_inf2), .o_is_zero(w_zero2)
  );

  // Special-case priority: NaN-producing cases first, then inf/x, x/0, 0/x or x/inf.
  always_comb begin
    w_special   = 1'b1;
    w_spec_quot = '0;
    w_spec_err  = ERR_NONE;
    if (w_nan1 || w_nan2 || (w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
      w_spec_quot = {w_sign, EXP_ONES, NAN_FRAC};
      w_spec_err  = ERR_NAN;
    end else if (w_inf1) begin
      w_spec_quot = {w_sign, EXP_ONES, {FRAC_WIDTH{1'b0}}};
    end else if (w_zero2) begin
      w_spec_quot = {w_sign, EXP_ONES, {FRAC_WIDTH{1'b0}}};
      w_spec_err  = ERR_OVF;
    end else if (w_zero1 || w_inf2) begin
      w_spec_quot = {w_sign, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      w_special   = 1'b0;
    end
  end

  // One restoring step; on the last step the full quotient is normalised directly.
  always_comb begin
    w_ge       = r_rem >= {1'b0, r_div};
    w_diff     = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    w_rem_next = w_diff << 1;
    w_q_next   = {r_q, w_ge};
    w_last     = (r_cnt == 4'd0);
    w_hi       = w_q_next[NITER-1];
    w_frac     = w_hi ? w_q_next[NITER-2 -: FRAC_WIDTH] : w_q_next[NITER-3 -: FRAC_WIDTH];
    w_exp      = w_hi ? r_exp : (r_exp - c_one);
`ifdef FP_DIV_ROUND_EN
    w_guard    = w_hi ? w_q_next[NITER-2-FRAC_WIDTH] : w_q_next[NITER-3-FRAC_WIDTH];
    w_sticky   = (w_hi && w_q_next[0]) || (w_diff != '0);
    w_frac_sum = {1'b0, w_frac} + {{FRAC_WIDTH{1'b0}}, (w_guard && (w_sticky || w_frac[0]))};
    w_frac_fin = w_frac_sum[FRAC_WIDTH-1:0];
    w_exp_fin  = w_exp + (w_frac_sum[FRAC_WIDTH] ? c_one : c_exp_zero);
`else
    w_frac_fin = w_frac;
    w_exp_fin  = w_exp;
`endif
    w_res_quot = {r_sign, w_exp_fin[EXP_WIDTH-1:0], w_frac_fin};
    w_res_err  = ERR_NONE;
    if (w_exp_fin >= c_exp_max) begin
      w_res_quot = {r_sign, EXP_ONES, {FRAC_WIDTH{1'b0}}};
      w_res_err  = ERR_OVF;
    end else if (w_exp_fin <= c_exp_zero) begin
      w_res_quot = {r_sign, {(DATA_WIDTH-1){1'b0}}};
      w_res_err  = ERR_UNF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_next = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last)   w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_exp  <= '0;
      r_sign <= 1'b0;
      r_quot <= '0;
      r_err  <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            if (w_special) begin
              r_quot <= w_spec_quot;
              r_err  <= w_spec_err;
            end else begin
              r_rem <= {1'b0, 1'b1, w_f1};
              r_div <= {1'b1, w_f2};
              r_q   <= '0;
              r_cnt <= c_cnt_init;
              r_exp <= $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + c_bias;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next[NITER-2:0];
          r_cnt <= r_cnt - 4'd1;
          if (w_last) begin
            r_quot <= w_res_quot;
            r_err  <= w_res_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign quot      = r_quot;
  assign error     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bf16_div_seq.sv
// ============================================================================
// tb_bf16_div_seq : directed-vector scoreboard bench for bf16_div_seq
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module tb_bf16_div_seq;

`ifdef FP_DIV_ROUND_EN
  localparam int          LAT_N   = 11;
  localparam logic [15:0] Q_THIRD = 16'h3EAB;
`else
  localparam int          LAT_N   = 10;
  localparam logic [15:0] Q_THIRD = 16'h3EAA;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [1:0]  error;

  bf16_div_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [1:0]  e;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops and compares whenever the DUT hands over a result.
  exp_t mon_ex;
  bit   mon_seen  = 1'b0;
  int   mon_first = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_seen = 1'b0;
      end else if (out_valid) begin
        if (!mon_seen) begin
          mon_seen  = 1'b1;
          mon_first = cyc;
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", {16'h0, quot}, 32'hDEAD);
          end else begin
            mon_ex = sb.pop_front();
            chk("quot", {16'h0, quot}, {16'h0, mon_ex.q});
            chk("error", {30'h0, error}, {30'h0, mon_ex.e});
            chk("latency", mon_first - mon_ex.acc, mon_ex.lat);
          end
          mon_seen = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] q, input logic [1:0] e, input int lat);
    exp_t t;
    t.q = q; t.e = e; t.lat = lat; t.acc = cyc;
    sb.push_back(t);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic [1:0] e, input int lat);
    int tmo;
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = a; divisor = b;
    tmo = 0;
    while (!in_ready && tmo < 100) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (!in_ready) chk("send_ready_timeout", {31'h0, in_ready}, 32'h1);
    else           push_exp(q, e, lat);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int tmo;
    tmo = 0;
    while ((sb.size() != 0 || out_valid) && tmo < 200) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (tmo >= 200) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tmo;
    int cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_quot", {16'h0, quot}, 32'h0);
    chk("reset_error", {30'h0, error}, 32'h0);

    send(16'h4040, 16'h3FC0, 16'h4000, 2'b00, LAT_N);   // 3.0 / 1.5
    send(16'h3F80, 16'h4040, Q_THIRD,  2'b00, LAT_N);   // 1 / 3
    send(16'hC0C0, 16'h4000, 16'hC040, 2'b00, LAT_N);   // -6 / 2
    send(16'h0000, 16'h0000, 16'h7FC0, 2'b11, 1);       // 0/0
    send(16'h3F80, 16'h0000, 16'h7F80, 2'b01, 1);       // x/0
    send(16'hBF80, 16'h0000, 16'hFF80, 2'b01, 1);       // -x/0
    send(16'h7FC1, 16'h3F80, 16'h7FC0, 2'b11, 1);       // NaN/x
    send(16'h7F80, 16'h7F80, 16'h7FC0, 2'b11, 1);       // inf/inf
    send(16'h7F80, 16'h4000, 16'h7F80, 2'b00, 1);       // inf/x
    send(16'h4000, 16'h7F80, 16'h0000, 2'b00, 1);       // x/inf
    send(16'h0000, 16'hC000, 16'h8000, 2'b00, 1);       // 0/-x keeps sign
    send(16'h0001, 16'h3F80, 16'h0000, 2'b00, 1);       // denormal flushes to zero
    send(16'h7F00, 16'h0080, 16'h7F80, 2'b01, LAT_N);   // overflow
    send(16'h0080, 16'h7F00, 16'h0000, 2'b10, LAT_N);   // underflow
    send(16'h7F00, 16'h3F80, 16'h7F00, 2'b00, LAT_N);   // e = 254
    send(16'h7F00, 16'h3F00, 16'h7F80, 2'b01, LAT_N);   // e = 255
    send(16'h0080, 16'h3F80, 16'h0080, 2'b00, LAT_N);   // e = 1
    send(16'h0080, 16'h4000, 16'h0000, 2'b10, LAT_N);   // e = 0
    drain();

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    send(16'h4040, 16'h3FC0, 16'h4000, 2'b00, LAT_N);
    tmo = 0;
    while (!out_valid && tmo < 50) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk("hold_reach_done", {31'h0, out_valid}, 32'h1);
    in_valid = 1'b1; dividend = 16'h3F80; divisor = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_quot", {16'h0, quot}, 32'h4000);
      chk("hold_error", {30'h0, error}, 32'h0);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
      chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'h0, in_ready}, 32'h1);
    chk("release_out_valid", {31'h0, out_valid}, 32'h0);
    push_exp(16'h7F80, 2'b01, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset in the middle of CALC aborts without any output.
    @(posedge clk); #1;
    chk("abort_pre_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; dividend = 16'h4040; divisor = 16'h3FC0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    chk("abort_quot", {16'h0, quot}, 32'h0);
    chk("abort_error", {30'h0, error}, 32'h0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("abort_no_output", cnt, 0);
    send(16'hC000, 16'h4000, 16'hBF80, 2'b00, LAT_N);   // -2 / 2
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
